// File: rtl/wb_dest_tracker_pkg.sv
// Shared CPU definitions for the write-back destination tracker.
// RegDst encodings, register-file defaults and the stage-entry bundle.
package wb_dest_tracker_pkg;

  localparam int REG_AW_DEF   = 5;
  localparam int LINK_REG_DEF = 31;

  typedef enum logic [1:0] {
    RD_RT   = 2'b00,
    RD_RD   = 2'b01,
    RD_LINK = 2'b10,
    RD_NONE = 2'b11
  } regdst_e;

  typedef struct packed {
    logic                  valid;
    logic [REG_AW_DEF-1:0] dest;
    logic                  is_load;
  } stage_t;

endpackage

// File: rtl/wb_dest_tracker_if.sv
// ID-side bundle of the destination tracker: decode inputs,
// source queries and the tracked-stage / forwarding outputs.
interface wb_dest_tracker_if #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2
);
  logic [1:0]            RegDst;
  logic [REG_AW-1:0]     rt;
  logic [REG_AW-1:0]     rd;
  logic                  RegWrite;
  logic                  MemToReg;
  logic                  Stall;
  logic                  Flush;
  logic [REG_AW-1:0]     rs_query;
  logic [REG_AW-1:0]     rt_query;
  logic                  rs_used;
  logic                  rt_used;
  logic [REG_AW-1:0]     WriteReg;
  logic [DEPTH-1:0]      stage_valid;
  logic [DEPTH*REG_AW-1:0] stage_dest;
  logic [SEL_W-1:0]      fwd_rs_sel;
  logic [SEL_W-1:0]      fwd_rt_sel;
  logic                  load_use;

  modport master (
    output RegDst, rt, rd, RegWrite, MemToReg,
    output Stall, Flush,
    output rs_query, rt_query, rs_used, rt_used,
    input  WriteReg, stage_valid, stage_dest,
    input  fwd_rs_sel, fwd_rt_sel, load_use
  );

  modport slave (
    input  RegDst, rt, rd, RegWrite, MemToReg,
    input  Stall, Flush,
    input  rs_query, rt_query, rs_used, rt_used,
    output WriteReg, stage_valid, stage_dest,
    output fwd_rs_sel, fwd_rt_sel, load_use
  );
endinterface

// File: rtl/wb_dest_tracker_dest_match_prio.sv
// Priority comparator: youngest tracked stage whose destination
// matches the query, reported as stage index + 1 (0 = no match).
module dest_match_prio #(
  parameter int REG_AW = 5,
  parameter int DEPTH  = 3,
  parameter int SEL_W  = 2
) (
  input  logic [DEPTH-1:0]        valid,
  input  logic [DEPTH*REG_AW-1:0] dest,
  input  logic [REG_AW-1:0]       query,
  input  logic                    used,
  output logic [SEL_W-1:0]        sel
);

  // Scan oldest to youngest so the youngest match overwrites.
  always_comb begin
    sel = '0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (used && (query != '0) && valid[k] &&
          (dest[k*REG_AW +: REG_AW] == query)) begin
        sel = SEL_W'(k + 1);
      end
    end
  end

endmodule

// File: rtl/wb_dest_tracker.sv
// Write-back destination select in ID, carried through a DEPTH-stage
// shift pipeline with forwarding-select and load-use hazard outputs.
module wb_dest_tracker
  import wb_dest_tracker_pkg::*;
#(
  parameter int REG_AW   = REG_AW_DEF,
  parameter int LINK_REG = LINK_REG_DEF,
  parameter int DEPTH    = 3,
  parameter int SEL_W    = 2
) (
  input  logic            CLK,
  input  logic            Reset,
  wb_dest_tracker_if.slave bus
);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] dest;
    logic              is_load;
  } entry_t;

  entry_t [DEPTH-1:0]      stage_q;
  entry_t [DEPTH-1:0]      stage_d;
  logic [REG_AW-1:0]       write_reg;
  logic                    id_wen;
  logic [DEPTH-1:0]        stg_valid;
  logic [DEPTH*REG_AW-1:0] stg_dest;

  always_comb begin
    write_reg = '0;
    unique case (bus.RegDst)
      RD_RT:   write_reg = bus.rt;
      RD_RD:   write_reg = bus.rd;
      RD_LINK: write_reg = REG_AW'(LINK_REG);
      RD_NONE: write_reg = '0;
      default: write_reg = '0;
    endcase
  end

  assign id_wen = bus.RegWrite && (bus.RegDst != RD_NONE) &&
                  (write_reg != '0);

  // Stage 0 takes a bubble on Stall/Flush; older stages always drain.
  always_comb begin
    stage_d = '0;
    if (!(bus.Stall || bus.Flush)) begin
      stage_d[0].valid   = id_wen;
      stage_d[0].dest    = id_wen ? write_reg : '0;
      stage_d[0].is_load = bus.MemToReg && id_wen;
    end
    for (int k = 1; k < DEPTH; k++) begin
      stage_d[k] = stage_q[k-1];
    end
  end

  always_ff @(posedge CLK) begin
    if (Reset) begin
      stage_q <= '0;
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    stg_valid = '0;
    stg_dest  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      stg_valid[k]                 = stage_q[k].valid;
      stg_dest[k*REG_AW +: REG_AW] = stage_q[k].dest;
    end
  end

  assign bus.WriteReg    = write_reg;
  assign bus.stage_valid = stg_valid;
  assign bus.stage_dest  = stg_dest;

  dest_match_prio #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .SEL_W  (SEL_W)
  ) u_rs_match (
    .valid (stg_valid),
    .dest  (stg_dest),
    .query (bus.rs_query),
    .used  (bus.rs_used),
    .sel   (bus.fwd_rs_sel)
  );

  dest_match_prio #(
    .REG_AW (REG_AW),
    .DEPTH  (DEPTH),
    .SEL_W  (SEL_W)
  ) u_rt_match (
    .valid (stg_valid),
    .dest  (stg_dest),
    .query (bus.rt_query),
    .used  (bus.rt_used),
    .sel   (bus.fwd_rt_sel)
  );

  // Hazard only while the load sits in EX; one stall moves it on.
  assign bus.load_use = stage_q[0].valid && stage_q[0].is_load &&
    ((bus.rs_used && (bus.rs_query != '0) &&
      (stage_q[0].dest == bus.rs_query)) ||
     (bus.rt_used && (bus.rt_query != '0) &&
      (stage_q[0].dest == bus.rt_query)));

endmodule

// File: tb/tb_wb_dest_tracker.sv
// Scoreboard bench for wb_dest_tracker: directed scenarios then
// random traffic, checked against a queue-based reference model.
module tb_wb_dest_tracker;

  localparam int AW    = 5;
  localparam int D     = 3;
  localparam int SW    = 2;
  localparam int LINK  = 31;

  typedef struct {
    int rdst; int rt; int rd;
    bit rw; bit mtr; bit stall; bit flush;
    int rsq; int rtq; bit rsu; bit rtu;
    bit rst;
  } in_t;

  typedef struct {
    bit v; int d; bit l;
  } ent_t;

  typedef struct {
    int wr; int sv; int sd;
    int frs; int frt; int lu;
  } exp_t;

  logic clk = 0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  in_t  cur;
  ent_t pipe[$];
  exp_t sb[$];

  wb_dest_tracker_if #(.REG_AW(AW), .DEPTH(D), .SEL_W(SW)) bus_if ();

  wb_dest_tracker #(
    .REG_AW   (AW),
    .LINK_REG (LINK),
    .DEPTH    (D),
    .SEL_W    (SW)
  ) dut (
    .CLK   (clk),
    .Reset (rst),
    .bus   (bus_if.slave)
  );

  always #5 clk = ~clk;

  function automatic in_t idle();
    in_t x;
    x.rdst = 3; x.rt = 0; x.rd = 0;
    x.rw = 0; x.mtr = 0; x.stall = 0; x.flush = 0;
    x.rsq = 0; x.rtq = 0; x.rsu = 0; x.rtu = 0;
    x.rst = 0;
    return x;
  endfunction

  function automatic int sel_wr(in_t x);
    case (x.rdst)
      0: return x.rt;
      1: return x.rd;
      2: return LINK;
      default: return 0;
    endcase
  endfunction

  function automatic int fwd(int q, bit used);
    if (!used || q == 0) return 0;
    foreach (pipe[k])
      if (pipe[k].v && pipe[k].d == q) return k + 1;
    return 0;
  endfunction

  // Advance the model by one edge using the inputs held at that edge.
  task automatic model_clock();
    ent_t e;
    int   wr;
    bit   wen;
    e.v = 0; e.d = 0; e.l = 0;
    if (cur.rst) begin
      pipe.delete();
      for (int k = 0; k < D; k++) pipe.push_back(e);
    end else begin
      wr  = sel_wr(cur);
      wen = cur.rw && cur.rdst != 3 && wr != 0;
      if (!(cur.stall || cur.flush) && wen) begin
        e.v = 1; e.d = wr; e.l = cur.mtr;
      end
      pipe.push_front(e);
      void'(pipe.pop_back());
    end
  endtask

  function automatic exp_t expect_now(in_t x);
    exp_t r;
    r.wr = sel_wr(x);
    r.sv = 0; r.sd = 0;
    foreach (pipe[k]) begin
      r.sv += int'(pipe[k].v) << k;
      r.sd += pipe[k].d << (k * AW);
    end
    r.frs = fwd(x.rsq, x.rsu);
    r.frt = fwd(x.rtq, x.rtu);
    r.lu  = int'(pipe[0].v && pipe[0].l &&
      ((x.rsu && x.rsq != 0 && pipe[0].d == x.rsq) ||
       (x.rtu && x.rtq != 0 && pipe[0].d == x.rtq)));
    return r;
  endfunction

  task automatic apply(in_t x);
    rst                = x.rst;
    bus_if.RegDst      = 2'(x.rdst);
    bus_if.rt          = AW'(x.rt);
    bus_if.rd          = AW'(x.rd);
    bus_if.RegWrite    = x.rw;
    bus_if.MemToReg    = x.mtr;
    bus_if.Stall       = x.stall;
    bus_if.Flush       = x.flush;
    bus_if.rs_query    = AW'(x.rsq);
    bus_if.rt_query    = AW'(x.rtq);
    bus_if.rs_used     = x.rsu;
    bus_if.rt_used     = x.rtu;
  endtask

  task automatic step(in_t x);
    @(posedge clk);
    #1;
    model_clock();
    cur = x;
    apply(x);
    sb.push_back(expect_now(x));
  endtask

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at %0t",
               name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expectation per cycle, sampled mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("WriteReg",    int'(bus_if.WriteReg),    e.wr);
        chk("stage_valid", int'(bus_if.stage_valid), e.sv);
        chk("stage_dest",  int'(bus_if.stage_dest),  e.sd);
        chk("fwd_rs_sel",  int'(bus_if.fwd_rs_sel),  e.frs);
        chk("fwd_rt_sel",  int'(bus_if.fwd_rt_sel),  e.frt);
        chk("load_use",    int'(bus_if.load_use),    e.lu);
      end
    end
  end

  initial begin
    in_t x;
    ent_t b;
    b.v = 0; b.d = 0; b.l = 0;
    for (int k = 0; k < D; k++) pipe.push_back(b);
    cur = idle();
    cur.rst = 1;
    apply(cur);

    // Reset for two cycles, then quiet.
    x = idle(); x.rst = 1;
    step(x); step(x);
    x = idle();
    step(x); step(x);

    // add r8 followed by dependent reads as it ages.
    x = idle(); x.rdst = 1; x.rd = 8; x.rw = 1;
    step(x);
    x = idle(); x.rsq = 8; x.rsu = 1;
    for (int i = 0; i < 4; i++) step(x);

    // lw r9, dependent read, stall once.
    x = idle(); x.rdst = 0; x.rt = 9; x.rw = 1; x.mtr = 1;
    step(x);
    x = idle(); x.rtq = 9; x.rtu = 1; x.stall = 1;
    step(x);
    x.stall = 0;
    step(x);

    // jal, RegDst none, rd = 0, then zero query.
    x = idle(); x.rdst = 2; x.rw = 1;
    step(x);
    x = idle(); x.rdst = 3; x.rd = 6; x.rw = 1; x.rsq = 31; x.rsu = 1;
    step(x);
    x = idle(); x.rdst = 1; x.rd = 0; x.rw = 1; x.rsq = 31; x.rsu = 1;
    step(x);
    x = idle(); x.rsq = 0; x.rsu = 1; x.rtq = 6; x.rtu = 1;
    step(x);

    // Same destination twice: youngest wins.
    x = idle(); x.rdst = 1; x.rd = 5; x.rw = 1;
    step(x); step(x);
    x = idle(); x.rsq = 5; x.rsu = 1; x.rtq = 5; x.rtu = 1;
    step(x);

    // Flushed writer, then reset with entries in flight.
    x = idle(); x.rdst = 1; x.rd = 12; x.rw = 1; x.flush = 1;
    step(x);
    x = idle(); x.rsq = 12; x.rsu = 1;
    step(x);
    for (int i = 1; i <= 3; i++) begin
      x = idle(); x.rdst = 1; x.rd = i; x.rw = 1;
      x.stall = 1; x.flush = (i == 2);
      x.stall = 0;
      step(x);
    end
    x = idle(); x.rst = 1; x.rsq = 2; x.rsu = 1;
    step(x);
    x = idle(); x.rsq = 2; x.rsu = 1;
    step(x); step(x);

    // Random traffic over a small register range.
    for (int i = 0; i < 400; i++) begin
      x.rdst  = int'($urandom_range(0, 3));
      x.rt    = int'($urandom_range(0, 7));
      x.rd    = int'($urandom_range(0, 7));
      x.rw    = ($urandom_range(0, 3) != 0);
      x.mtr   = ($urandom_range(0, 2) == 0);
      x.stall = ($urandom_range(0, 5) == 0);
      x.flush = ($urandom_range(0, 7) == 0);
      x.rsq   = ($urandom_range(0, 7) == 0) ? LINK :
                int'($urandom_range(0, 7));
      x.rtq   = int'($urandom_range(0, 7));
      x.rsu   = ($urandom_range(0, 4) != 0);
      x.rtu   = ($urandom_range(0, 4) != 0);
      x.rst   = ($urandom_range(0, 49) == 0);
      step(x);
    end
    step(idle());

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(posedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/wb_dest_tracker.md
Name: wb_dest_tracker

Overview:
- Parametrised successor to the destination-register multiplexer in the pipelined CPU.
- Selects the write-back destination (rt / rd / link register / none) in ID.
- Carries that destination through a DEPTH-stage shift pipeline (EX, MEM, WB, …).
- Answers source-operand queries from ID: forwarding-source selection and load-use hazard detection, for the forwarding unit and the hazard/stall unit.

Parameters:
REG_AW, 5, register-address width in bits
LINK_REG, 31, destination used when RegDst=2'b10 (jal)
DEPTH, 3, number of tracked stages after ID (stage 0 = EX, stage DEPTH-1 = WB); legal range 1..7
SEL_W, 2, width of the forward-select outputs; must satisfy 2^SEL_W > DEPTH

Ports:
CLK  in  1  clock, rising edge
Reset  in  1  synchronous, active-high reset
RegDst  in  2  00 = rt, 01 = rd, 10 = LINK_REG, 11 = no write
rt  in  REG_AW  ID-stage rt field
rd  in  REG_AW  ID-stage rd field
RegWrite  in  1  ID instruction writes the register file
MemToReg  in  1  ID instruction is a load
Stall  in  1  hold ID and insert a bubble into EX
Flush  in  1  kill the ID instruction (insert a bubble into EX)
rs_query  in  REG_AW  ID source register A
rt_query  in  REG_AW  ID source register B
rs_used  in  1  source A is read by the ID instruction
rt_used  in  1  source B is read by the ID instruction
WriteReg  out  REG_AW  combinational selected destination for the ID instruction
stage_valid  out  DEPTH  per-stage "will write" flag
stage_dest  out  DEPTH*REG_AW  per-stage destination; stage k occupies bits [k*REG_AW +: REG_AW]
fwd_rs_sel  out  SEL_W  0 = no match, k = youngest matching stage k-1
fwd_rt_sel  out  SEL_W  same encoding, for rt_query
load_use  out  1  load-use hazard: stall required

Behaviour:
- WriteReg:
  - Combinational: 00 → rt, 01 → rd, 10 → LINK_REG.
  - 11 → 0, and the instruction is treated as non-writing.
- ID write-enable: id_wen = RegWrite & (RegDst != 11) & (WriteReg != 0).
- Register 0 is never tracked as valid.
- Stage registers per stage: valid, dest, is_load.
- Reset: every valid = 0, dest = 0, is_load = 0, so all outputs read 0.
  - Reset has priority over Stall and Flush.
  - Reset asserted mid-operation clears every in-flight entry on that edge.
- Each rising edge without Reset, stage 0 loads:
  - if Stall or Flush: a bubble (valid = 0, dest = 0, is_load = 0);
  - otherwise: {id_wen, WriteReg, MemToReg & id_wen}.
- Stages 1..DEPTH-1 always load from stage k-1 on every edge, Stall included: later stages drain while ID is held.
- Stage DEPTH-1 is the WB stage; its entry is discarded on the next edge.
- Stall and Flush asserted together behave as a single bubble.
- Latency:
  - A destination written in ID appears in stage 0 one cycle later.
  - It appears in stage k after k+1 cycles.
- Forward select (fwd_rs_sel shown; fwd_rt_sel is identical using rt_query and rt_used):
  - Combinational.
  - Equals the smallest k in 0..DEPTH-1 with stage_valid[k] & (stage_dest[k] == rs_query) & rs_used, reported as value k+1.
  - Equals 0 if there is no match or rs_query == 0.
  - The youngest stage wins when several stages match.
- load_use:
  - Asserted when stage 0 holds a valid load whose dest equals rs_query (with rs_used) or rt_query (with rt_used), query register nonzero.
  - Combinational; the hazard unit feeds it back as Stall.
  - After one stalled cycle the load moves to stage 1, so load_use drops and forwarding from stage 1 takes over.
- No wrap-around and no full/empty condition: this is a fixed-depth shift pipeline.

Decomposition:
- Shared CPU package:
  - RegDst encodings: RD_RT = 2'b00, RD_RD = 2'b01, RD_LINK = 2'b10, RD_NONE = 2'b11.
  - LINK_REG default, REG_AW default.
  - Stage-entry struct {valid, dest, is_load}.
- One natural sub-module: dest_match_prio.
  - Priority comparator that takes the stage arrays and one query, and returns the SEL_W select.
  - Instantiated twice, once for rs and once for rt.

Test Plan:
- Reset held 2 cycles, then released with no RegWrite → stage_valid = 0, both selects = 0, load_use = 0.
- add with RegDst = 01, rd = 8, RegWrite = 1; next cycle ID queries rs_query = 8, rs_used = 1 → fwd_rs_sel = 1; one cycle later 2; then 3; then 0.
- lw with RegDst = 00, rt = 9, MemToReg = 1; next ID instruction has rt_query = 9, rt_used = 1 → load_use = 1; apply Stall 1 cycle → stage 0 bubble, load in stage 1, load_use = 0, fwd_rt_sel = 2.
- jal with RegDst = 10 → WriteReg = 31, stage 0 dest = 31 after 1 cycle; RegDst = 11 or rd = 0 with RegWrite = 1 → entry invalid, a query of 0 returns sel 0.
- Same destination 5 written in two consecutive cycles → query of 5 returns fwd sel 1 (youngest), not 2.
- Flush while a valid writing instruction is in ID, then Reset pulsed while 3 entries are in flight → flushed entry never becomes valid; after Reset all stage_valid = 0 on the next cycle.
